// File: rtl/truth_table_sweep.sv
// Exhaustive sweep of a 4-input combinational block: drives all 16 patterns on
// A..D in ascending order, holds each for HOLD cycles, and captures f into tt.
module truth_table_sweep #(
    parameter int unsigned HOLD = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        f,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic [15:0] tt,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DONE
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q,   idx_d;
    logic [7:0]  hcnt_q,  hcnt_d;
    logic [3:0]  pat_q,   pat_d;
    logic [15:0] tt_q,    tt_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

    // NOTE: every output of this block is assigned a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hcnt_d  = hcnt_q;
        pat_d   = pat_q;
        tt_d    = tt_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tt_d    = 16'h0000;
                    idx_d   = 4'd0;
                    hcnt_d  = 8'd0;
                    pat_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = S_DRIVE;
                end
            end

            S_DRIVE: begin
                if (hcnt_q == HOLD_LAST) begin
                    // End of hold window: f has settled for the pattern on A..D.
                    tt_d[idx_q] = f;
                    hcnt_d      = 8'd0;
                    if (idx_q != 4'hF) begin
                        idx_d = idx_q + 4'd1;
                        pat_d = idx_q + 4'd1;
                    end else begin
                        pat_d   = 4'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end

            S_DONE: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its peers regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            hcnt_q  <= 8'd0;
            pat_q   <= 4'd0;
            tt_q    <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hcnt_q  <= hcnt_d;
            pat_q   <= pat_d;
            tt_q    <= tt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign {A, B, C, D} = pat_q;
    assign tt           = tt_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: doc/truth_table_sweep.md
# truth_table_sweep

Exhaustive stimulus-and-capture stage for a 4-input combinational function block with inputs A, B, C, D and output f. On `start`, the block drives all 16 input patterns in ascending binary order, holding each for `HOLD` clock cycles. At the end of each hold window it samples `f` and records it in a 16-bit truth-table register. The block sits directly upstream of the function under test (it drives A–D) and directly downstream of it (it consumes f), and replaces hand-written per-pattern stimulus with a synthesizable sweep.

## Interface
Parameters:
- `HOLD`, default 20: clock cycles each pattern is held. Legal range 1..255. The hold counter is 8 bits wide.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  sweep request; sampled on the rising edge; honoured only in IDLE.
- `f`  input  1  output of the function under test; sampled on the rising edge.
- `A`  output  1  pattern bit 3 (MSB), registered.
- `B`  output  1  pattern bit 2, registered.
- `C`  output  1  pattern bit 1, registered.
- `D`  output  1  pattern bit 0 (LSB), registered.
- `tt`  output  16  captured truth table; `tt[i]` = f sampled while {A,B,C,D} = i.
- `busy`  output  1  high while a sweep is in progress.
- `done`  output  1  one-cycle pulse when the sweep completes.

## Operation
- Reset state, forced immediately while `rst_n`=0:
  - state = IDLE
  - A, B, C, D = 0
  - `tt` = 16'h0000
  - `busy` = 0, `done` = 0
  - `idx` = 0, `hcnt` = 0
- Internal registers:
  - `idx` (4 bits): current pattern; {A,B,C,D} = `idx` at all times in DRIVE.
  - `hcnt` (8 bits): hold counter.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - `start`=1 → `tt` ← 0, `idx` ← 0, `hcnt` ← 0, `busy` ← 1, go to DRIVE.
  - `start`=0 → stay in IDLE; `tt` retains its last sweep result.
- DRIVE:
  - `hcnt` < `HOLD`-1 → `hcnt` ← `hcnt`+1.
  - `hcnt` = `HOLD`-1 → `tt[idx]` ← f, `hcnt` ← 0.
    - If `idx` < 15: `idx` ← `idx`+1.
    - If `idx` = 15: A–D ← 0, `busy` ← 0, `done` ← 1, go to DONE.
  - `start` is ignored.
- DONE:
  - `done` ← 0, go to IDLE.
  - `start` is ignored in this cycle.
  - The next sweep can be accepted one cycle after DONE.
- `idx` never wraps within a sweep. The 15→0 transition happens only via DONE/IDLE.
- With `HOLD`=1, a sample is taken on every DRIVE cycle.

## Timing
- Let edge k be the rising edge at which `start` is accepted in IDLE.
- Pattern i (0..15) is driven on A–D from edge k+i·`HOLD` until edge k+(i+1)·`HOLD`.
- Sampling of pattern i:
  - f is sampled at edge k+(i+1)·`HOLD`, on the settled value for pattern i.
  - Pattern i+1 appears at that same edge.
  - f is assumed combinational, settling within one clock period.
- At edge k+16·`HOLD`:
  - `tt[15]` is written.
  - `busy` falls, `done` rises, A–D return to 0.
- At edge k+16·`HOLD`+1: `done` falls.
- Sweep latency from start edge to done edge: 16·`HOLD` cycles. Default `HOLD`=20 gives 320 cycles.
- `tt` is stable and valid from the `done` edge until the next accepted `start`.
- Reset asserted mid-sweep:
  - All outputs go to their reset values asynchronously.
  - The partial `tt` is discarded.
  - No `done` pulse is produced.

## Test plan
- Reset check: assert `rst_n`=0 mid-cycle → A–D=0, `tt`=0, `busy`=0, `done`=0 immediately, without waiting for a clock edge.
- Parity function: f = A^B^C^D, `HOLD`=20, pulse `start` → `busy` high 320 cycles, then one `done` pulse, `tt`=16'h6996.
- Bit-ordering check: f = A&~D → `tt`=16'h5500. f = A&B&C&D → `tt`=16'h8000.
- `start` while busy:
  - Re-pulse `start` at cycles 50 and 319 → exactly one `done` pulse, at cycle 320.
  - `start` in the DONE cycle is ignored; `start` one cycle later begins a new sweep and clears `tt`.
- Reset mid-sweep: assert `rst_n` while `idx`=7 → `tt`=0, no `done` pulse. After release, `start` gives a full sweep with the correct `tt`.
- `HOLD`=1:
  - {A,B,C,D} increments every cycle 0→15.
  - `done` occurs 16 cycles after the start edge.
  - Parity f gives `tt`=16'h6996.
